// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: I-cache, D-cache and backing-memory signals of mem_arbiter.
// slave is the arbiter's view; master is the view of the caches and memory around it.
interface mem_arbiter_if #(
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned ADDR_BITS = 32
);
  logic                 i_req;
  logic [ADDR_BITS-1:0] i_addr;
  logic                 i_gnt;
  logic                 i_valid;
  logic [LINE_BITS-1:0] i_rdata;

  logic                 d_req;
  logic                 d_we;
  logic [ADDR_BITS-1:0] d_addr;
  logic [LINE_BITS-1:0] d_wdata;
  logic                 d_gnt;
  logic                 d_valid;
  logic [LINE_BITS-1:0] d_rdata;

  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [LINE_BITS-1:0] mem_wdata;
  logic                 mem_ready;
  logic                 mem_valid;
  logic [LINE_BITS-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  mem_ready, mem_valid, mem_rdata,
    output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output mem_ready, mem_valid, mem_rdata,
    input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory port between I-cache refills and D-cache refill/writeback.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the D-cache wins every tie.
module mem_arbiter #(
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned ADDR_BITS = 32
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int unsigned OFFS_BITS = $clog2(LINE_BITS / 8);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t               state;
  state_t               state_n;
  owner_t               owner;
  logic                 lat_we;
  logic [ADDR_BITS-1:0] lat_addr;
  logic [LINE_BITS-1:0] lat_wdata;
  logic [LINE_BITS-1:0] lat_rdata;

  logic                 take_c;
  logic                 sel_d_c;
  logic [ADDR_BITS-1:0] sel_addr_c;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_owner;

  // On a tie, serve whichever requester was not granted most recently.
  assign sel_d_c = bus.d_req && (!bus.i_req || last_owner == OWN_I);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= OWN_I;
    end else if (take_c) begin
      last_owner <= sel_d_c ? OWN_D : OWN_I;
    end
  end
`else
  assign sel_d_c = bus.d_req;
`endif

  // Gating with reset keeps the combinational grants low while reset overrides the inputs.
  assign take_c     = (state == IDLE) && (bus.i_req || bus.d_req) && !reset;
  assign sel_addr_c = sel_d_c ? bus.d_addr : bus.i_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    bus.i_gnt     = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.i_valid   = 1'b0;
    bus.d_valid   = 1'b0;
    bus.i_rdata   = '0;
    bus.d_rdata   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: begin
        if (take_c) begin
          bus.i_gnt = !sel_d_c;
          bus.d_gnt = sel_d_c;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = lat_we;
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
        if (bus.mem_ready) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_valid) begin
          state_n = RESP;
        end
      end
      RESP: begin
        if (owner == OWN_D) begin
          bus.d_valid = 1'b1;
          bus.d_rdata = lat_rdata;
        end else begin
          bus.i_valid = 1'b1;
          bus.i_rdata = lat_rdata;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Capture the winning request at grant and the memory line at completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_I;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rdata <= '0;
    end else begin
      if (take_c) begin
        owner     <= sel_d_c ? OWN_D : OWN_I;
        lat_we    <= sel_d_c && bus.d_we;
        lat_addr  <= {sel_addr_c[ADDR_BITS-1:OFFS_BITS], {OFFS_BITS{1'b0}}};
        lat_wdata <= (sel_d_c && bus.d_we) ? bus.d_wdata : '0;
      end
      if (state == WAIT && bus.mem_valid) begin
        lat_rdata <= lat_we ? '0 : bus.mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, reset corner cases and a randomized run against a
// transaction-level model (pending requests, arbitration rule, line-addressed memory array).
module tb_mem_arbiter;
  localparam int unsigned LW = 128;
  localparam int unsigned AW = 32;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic           ir;
    logic           dr;
    logic           dwe;
    logic [AW-1:0]  ia;
    logic [AW-1:0]  da;
    logic [LW-1:0]  dwd;
    logic [LW-1:0]  mrd;
    int             rdly;
    int             vdly;
    bit             hold;
    logic           exp_d;
    logic [AW-1:0]  exp_addr;
    logic           exp_we;
    logic [LW-1:0]  exp_wd;
    logic [LW-1:0]  exp_rd;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_arbiter_if #(.LINE_BITS(LW), .ADDR_BITS(AW)) bus ();

  mem_arbiter #(.LINE_BITS(LW), .ADDR_BITS(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [LW-1:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic vec_t mk(logic ir, logic dr, logic dwe, logic [AW-1:0] ia, logic [AW-1:0] da,
                              logic [LW-1:0] dwd, logic [LW-1:0] mrd, int rdly, int vdly, bit hold,
                              logic exp_d, logic [AW-1:0] exp_addr, logic exp_we,
                              logic [LW-1:0] exp_wd, logic [LW-1:0] exp_rd);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dwe = dwe; v.ia = ia; v.da = da; v.dwd = dwd; v.mrd = mrd;
    v.rdly = rdly; v.vdly = vdly; v.hold = hold; v.exp_d = exp_d; v.exp_addr = exp_addr;
    v.exp_we = exp_we; v.exp_wd = exp_wd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_i_gnt"},     LW'(bus.i_gnt),     '0);
    chk({tag, "_d_gnt"},     LW'(bus.d_gnt),     '0);
    chk({tag, "_i_valid"},   LW'(bus.i_valid),   '0);
    chk({tag, "_d_valid"},   LW'(bus.d_valid),   '0);
    chk({tag, "_i_rdata"},   bus.i_rdata,        '0);
    chk({tag, "_d_rdata"},   bus.d_rdata,        '0);
    chk({tag, "_mem_req"},   LW'(bus.mem_req),   '0);
    chk({tag, "_mem_we"},    LW'(bus.mem_we),    '0);
    chk({tag, "_mem_addr"},  LW'(bus.mem_addr),  '0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,      '0);
  endtask

  // Called at posedge+1 with the arbiter idle; returns at posedge+1 of the following idle cycle.
  task automatic run_txn(input vec_t v);
    bus.i_req     = v.ir;
    bus.d_req     = v.dr;
    bus.d_we      = v.dwe;
    bus.i_addr    = v.ia;
    bus.d_addr    = v.da;
    bus.d_wdata   = v.dwd;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_valid = 1'($urandom_range(0, 1));
    #2;
    chk("grant_i", LW'(bus.i_gnt), LW'(!v.exp_d));
    chk("grant_d", LW'(bus.d_gnt), LW'(v.exp_d));
    chk("idle_mem_req", LW'(bus.mem_req), '0);
    @(posedge clk); #1;
    if (v.exp_d) begin
      bus.d_req = 1'b0; bus.d_addr = $urandom; bus.d_wdata = r128(); bus.d_we = 1'($urandom_range(0, 1));
    end else begin
      bus.i_req = 1'b0; bus.i_addr = $urandom;
    end
    if (!v.hold) begin
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
    end
    for (int r = 0; r <= v.rdly; r++) begin
      bus.mem_ready = (r == v.rdly);
      bus.mem_valid = 1'($urandom_range(0, 1));
      #2;
      chk("issue_mem_req",   LW'(bus.mem_req),  LW'(1'b1));
      chk("issue_mem_addr",  LW'(bus.mem_addr), LW'(v.exp_addr));
      chk("issue_mem_we",    LW'(bus.mem_we),   LW'(v.exp_we));
      chk("issue_mem_wdata", bus.mem_wdata,     v.exp_wd);
      chk("issue_gnt",       LW'({bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid}), '0);
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    for (int w = 0; w <= v.vdly; w++) begin
      bus.mem_valid = (w == v.vdly);
      bus.mem_rdata = (w == v.vdly) ? v.mrd : r128();
      bus.mem_ready = 1'($urandom_range(0, 1));
      #2;
      chk("wait_mem_req", LW'(bus.mem_req), '0);
      chk("wait_gnt",     LW'({bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid}), '0);
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    bus.mem_valid = 1'($urandom_range(0, 1));
    bus.mem_rdata = r128();
    #2;
    chk("resp_i_valid", LW'(bus.i_valid), LW'(!v.exp_d));
    chk("resp_d_valid", LW'(bus.d_valid), LW'(v.exp_d));
    chk("resp_i_rdata", bus.i_rdata, v.exp_d ? '0 : v.exp_rd);
    chk("resp_d_rdata", bus.d_rdata, v.exp_d ? v.exp_rd : '0);
    chk("resp_quiet",   LW'({bus.i_gnt, bus.d_gnt, bus.mem_req}), '0);
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
  endtask

  vec_t                vecs [9];
  logic [LW-1:0]       mem_m [logic [AW-1:0]];
  logic                pi, pd, dwe, win_d, we, last_d;
  logic [AW-1:0]       ia, da, ea;
  logic [LW-1:0]       dwd, mrd, erd;

  initial begin
    logic [LW-1:0] a5, l1, l2, l3, l4, l5, cb;
    a5 = {16{8'hA5}};
    l1 = {4{32'h1111_2222}};
    l2 = {4{32'h3333_4444}};
    l3 = {4{32'h5555_6666}};
    l4 = {4{32'h7777_8888}};
    l5 = {4{32'h9999_AAAA}};
    cb = {4{32'hCAFE_BABE}};
    vecs[0] = mk(1, 0, 0, 32'h104, 32'h0, '0, a5, 0, 0, 0, 0, 32'h100, 0, '0, a5);
    vecs[1] = mk(1, 1, 0, 32'h1008, 32'h201C, 128'hDEAD, l1, 0, 0, 0, 1, 32'h2010, 0, '0, l1);
    vecs[2] = mk(1, 1, 0, 32'h1008, 32'h201C, 128'hDEAD, l2, 0, 0, 0, !RR,
                 RR ? 32'h1000 : 32'h2010, 0, '0, l2);
    vecs[3] = mk(1, 1, 0, 32'h1008, 32'h201C, 128'hDEAD, l3, 0, 0, 0, 1, 32'h2010, 0, '0, l3);
    vecs[4] = mk(0, 1, 1, 32'h0, 32'h200, 128'h1234, {4{32'hFFFF_FFFF}}, 0, 0, 0,
                 1, 32'h200, 1, 128'h1234, '0);
    vecs[5] = mk(1, 0, 0, 32'h3C, 32'h0, '0, l3, 2, 3, 0, 0, 32'h30, 0, '0, l3);
    vecs[6] = mk(1, 1, 0, 32'h88, 32'h48, 128'h77, l4, 4, 1, 1, 1, 32'h40, 0, '0, l4);
    vecs[7] = mk(1, 0, 0, 32'h88, 32'h0, '0, l5, 0, 0, 0, 0, 32'h80, 0, '0, l5);
    vecs[8] = mk(0, 1, 1, 32'h0, 32'hFFFF_FFFF, cb, l1, 1, 0, 0, 1, 32'hFFFF_FFF0, 1, cb, '0);

    // Reset overrides active requests and a stray memory completion.
    reset = 1'b1;
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b1;
    bus.i_addr = 32'h104; bus.d_addr = 32'h200; bus.d_wdata = r128();
    bus.mem_ready = 1'b1; bus.mem_valid = 1'b1; bus.mem_rdata = r128();
    repeat (3) @(posedge clk);
    #3;
    chk_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_valid = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i]);
    end

    // Reset while waiting on memory, then a late completion must be ignored.
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    #2;
    chk("rstwait_gnt", LW'(bus.i_gnt), LW'(1'b1));
    @(posedge clk); #1;
    bus.i_req = 1'b0; bus.mem_ready = 1'b1;
    #2;
    chk("rstwait_mem_req", LW'(bus.mem_req), LW'(1'b1));
    @(posedge clk); #1;
    bus.mem_ready = 1'b0; reset = 1'b1;
    #2;
    chk("rstwait_in_wait", LW'(bus.mem_req), '0);
    @(posedge clk); #1;
    reset = 1'b0; bus.mem_valid = 1'b1; bus.mem_rdata = r128();
    #2;
    chk_zero("rstwait_a");
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    #2;
    chk_zero("rstwait_b");
    @(posedge clk); #1;
    // Reset restores last-served to I, so both builds hand a tie to D.
    run_txn(mk(1, 1, 0, 32'h500, 32'h604, '0, l2, 0, 0, 0, 1, 32'h600, 0, '0, l2));

    last_d = 1'b1;
    pi = 1'b0;
    pd = 1'b0;
    ia = '0; da = '0; dwe = 1'b0; dwd = '0;
    for (int t = 0; t < 60; t++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin
        pi = 1'b1; ia = AW'($urandom_range(0, 1023));
      end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd = 1'b1; da = AW'($urandom_range(0, 1023));
        dwe = 1'($urandom_range(0, 1)); dwd = r128();
      end
      if (!pi && !pd) begin
        pi = 1'b1; ia = AW'($urandom_range(0, 1023));
      end
      if (pi && pd) win_d = RR ? !last_d : 1'b1;
      else          win_d = pd;
      ea = (win_d ? da : ia) & ~AW'(LW / 8 - 1);
      we = win_d && dwe;
      if (we) begin
        mrd = r128();
        erd = '0;
        mem_m[ea] = dwd;
      end else begin
        mrd = mem_m.exists(ea) ? mem_m[ea] : {ea, ~ea, ea ^ 32'h5A5A_5A5A, 32'h0BAD_F00D};
        erd = mrd;
      end
      run_txn(mk(pi, pd, dwe, ia, da, dwd, mrd, $urandom_range(0, 3), $urandom_range(0, 3), 1,
                 win_d, ea, we, we ? dwd : '0, erd));
      if (win_d) pd = 1'b0;
      else       pi = 1'b0;
      last_d = win_d;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: LINE_BITS, 128, cache-line width; ADDR_BITS, 32, byte-address width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  instruction-cache refill request (read only).
REQ-005 i_addr  input  ADDR_BITS  instruction line address.
REQ-006 i_gnt  output  1  request captured this cycle.
REQ-007 i_valid  output  1  one-cycle completion pulse, i_rdata valid.
REQ-008 i_rdata  output  LINE_BITS  refill line.
REQ-009 d_req  input  1  data-cache request (refill or writeback).
REQ-010 d_we  input  1  1 = writeback, 0 = refill.
REQ-011 d_addr  input  ADDR_BITS  data line address.
REQ-012 d_wdata  input  LINE_BITS  writeback line.
REQ-013 d_gnt  output  1  request captured this cycle.
REQ-014 d_valid  output  1  one-cycle completion pulse (read and write).
REQ-015 d_rdata  output  LINE_BITS  refill line; 0 on write completion.
REQ-016 mem_req  output  1  request to backing memory.
REQ-017 mem_we  output  1  write enable to memory.
REQ-018 mem_addr  output  ADDR_BITS  memory address.
REQ-019 mem_wdata  output  LINE_BITS  memory write line.
REQ-020 mem_ready  input  1  memory accepts mem_req this cycle.
REQ-021 mem_valid  input  1  memory completion; mem_rdata valid for reads.
REQ-022 mem_rdata  input  LINE_BITS  memory read line.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight.
REQ-024 IDLE: if any req, select owner, assert owner gnt combinationally that cycle, latch owner/we/addr/wdata, go ISSUE; else stay IDLE.
REQ-025 i_addr/d_addr SHALL be latched with low log2(LINE_BITS/8) bits forced to 0.
REQ-026 ISSUE: mem_req=1 with latched mem_we/mem_addr/mem_wdata; mem_ready=1 -> WAIT, else hold ISSUE with stable outputs.
REQ-027 WAIT: mem_req=0; mem_valid=1 -> latch mem_rdata (0 for writes), go RESP.
REQ-028 mem_valid SHALL be ignored in IDLE, ISSUE and RESP.
REQ-029 RESP: owner valid=1 for exactly one cycle with latched rdata, go IDLE; non-owner valid=0.
REQ-030 Minimum latency: req in cycle 0 -> valid in cycle 3 (mem_ready in cycle 1, mem_valid in cycle 2).
REQ-031 Requests SHALL be ignored and gnt held 0 outside IDLE; requester drops req after gnt until its valid.
REQ-032 Instruction requests SHALL force mem_we=0 regardless of other inputs.
REQ-033 A new request SHALL be grantable in the IDLE cycle immediately following RESP.
REQ-034 mem_wdata SHALL be 0 when latched operation is a read.

Reset
REQ-035 reset=1 SHALL force state IDLE, all outputs 0, latched fields 0, last_owner=I, overriding all inputs.
REQ-036 Reset mid-transaction SHALL drop it without any valid pulse; a later stray mem_valid is ignored per REQ-028.

Configuration
REQ-037 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous i_req and d_req in IDLE, grant the requester not served last (last_owner updated at each grant).
REQ-038 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, d_req always wins ties; last_owner register absent.

Verification
REQ-039 Single i_req addr 0x104, mem_ready=1, mem_valid next cycle, mem_rdata=0xA5..A5 -> mem_addr 0x100, i_valid in cycle 3, i_rdata=0xA5..A5.
REQ-040 d_req d_we=1 addr 0x200 d_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234, d_valid pulse, d_rdata=0.
REQ-041 Simultaneous i_req and d_req three times -> fixed build: D,D,D served first; round-robin build: D,I,D.
REQ-042 mem_ready low 4 cycles in ISSUE -> mem_req and mem_addr stable 5 cycles, no gnt to waiting requester.
REQ-043 reset asserted in WAIT, then mem_valid=1 -> no i_valid/d_valid, state IDLE, all outputs 0.
